// File: rtl/pcs_tx_enc.sv
// 64b/66b PCS transmit encoder with optional x^58+x^39+1 scrambler and gearbox pacing.
// One-cycle latency from accepted block to enc_v_o; phy_ready_o drops one cycle every GB_PERIOD.
module pcs_tx_enc #(
  parameter int SCRAMBLE  = 1,
  parameter int GB_PERIOD = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phy_ctrl_v_i,
  input  logic [63:0] phy_data_i,
  input  logic [1:0]  phy_start_i,
  input  logic        phy_idle_i,
  input  logic        phy_term_i,
  input  logic [3:0]  phy_term_len_i,
  output logic        phy_ready_o,
  output logic        enc_v_o,
  output logic [1:0]  enc_head_o,
  output logic [63:0] enc_data_o,
  output logic        enc_err_o
);

  localparam int CNT_W = (GB_PERIOD > 1) ? $clog2(GB_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((GB_PERIOD > 0) ? GB_PERIOD - 1 : 0);
  localparam logic [63:0] ERR_PAY = {{8{7'h1E}}, 8'h1E};

  logic [CNT_W-1:0] gb_cnt;
  logic             stall;
  logic             accept;
  logic [1:0]       blk_head;
  logic [63:0]      blk_pay;
  logic             blk_err;
  logic [7:0]       term_code;
  logic [63:0]      term_mask;
  logic [57:0]      scr_st;
  logic [57:0]      scr_nxt;
  logic [63:0]      scr_pay;
  logic [63:0]      out_pay;

  // Pacing counter free-runs out of reset; the last slot is the gearbox stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      gb_cnt <= '0;
    end else if (GB_PERIOD > 0) begin
      gb_cnt <= (gb_cnt == CNT_LAST) ? '0 : gb_cnt + CNT_W'(1);
    end
  end

  assign stall       = (GB_PERIOD > 0) && (gb_cnt == CNT_LAST);
  assign phy_ready_o = ~reset & ~stall;
  assign accept      = phy_ready_o;

  always_comb begin
    case (phy_term_len_i[2:0])
      3'd0:    term_code = 8'h87;
      3'd1:    term_code = 8'h99;
      3'd2:    term_code = 8'hAA;
      3'd3:    term_code = 8'hB4;
      3'd4:    term_code = 8'hCC;
      3'd5:    term_code = 8'hD2;
      3'd6:    term_code = 8'hE1;
      default: term_code = 8'hFF;
    endcase
    term_mask = (64'h1 << {phy_term_len_i[2:0], 3'b000}) - 64'h1;
  end

  always_comb begin
    blk_head = 2'b10;
    blk_pay  = ERR_PAY;
    blk_err  = 1'b1;
    if (phy_idle_i) begin
      blk_pay = 64'h1E;
      blk_err = 1'b0;
    end else if (!phy_ctrl_v_i) begin
      if (phy_start_i == 2'b00 && !phy_term_i) begin
        blk_head = 2'b01;
        blk_pay  = phy_data_i;
        blk_err  = 1'b0;
      end
    end else if (phy_start_i == 2'b01 && !phy_term_i) begin
      blk_pay = {phy_data_i[63:8], 8'h78};
      blk_err = 1'b0;
    end else if (phy_start_i == 2'b10 && !phy_term_i) begin
      blk_pay = {phy_data_i[63:40], 32'h0, 8'h33};
      blk_err = 1'b0;
    end else if (phy_start_i == 2'b00 && phy_term_i && !phy_term_len_i[3]) begin
      blk_pay = ((phy_data_i & term_mask) << 8) | {56'h0, term_code};
      blk_err = 1'b0;
    end
  end

  // Bit-serial self-synchronous scrambler unrolled over the 64 payload bits, LSB first.
  always_comb begin
    scr_nxt = scr_st;
    scr_pay = '0;
    for (int i = 0; i < 64; i++) begin
      scr_pay[i] = blk_pay[i] ^ scr_nxt[38] ^ scr_nxt[57];
      scr_nxt    = {scr_nxt[56:0], scr_pay[i]};
    end
  end

  assign out_pay = (SCRAMBLE != 0) ? scr_pay : blk_pay;

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_v_o    <= 1'b0;
      enc_err_o  <= 1'b0;
      enc_head_o <= 2'b00;
      enc_data_o <= '0;
      scr_st     <= {58{1'b1}};
    end else begin
      enc_v_o   <= accept;
      enc_err_o <= accept & blk_err;
      if (accept) begin
        enc_head_o <= blk_head;
        enc_data_o <= out_pay;
        if (SCRAMBLE != 0) begin
          scr_st <= scr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcs_tx_enc.sv
// Bench for pcs_tx_enc: plain and scrambled instances share stimulus; scoreboard queue of expected blocks.
module tb_pcs_tx_enc;
  localparam int GB = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_v;
  logic [63:0] din;
  logic [1:0]  start;
  logic        idle;
  logic        term;
  logic [3:0]  tlen;

  logic        rdy0, v0, err0, rdy1, v1, err1;
  logic [1:0]  head0, head1;
  logic [63:0] data0, data1;

  always #5 clk = ~clk;

  pcs_tx_enc #(.SCRAMBLE(0), .GB_PERIOD(GB)) u_plain (
    .clk(clk), .reset(reset), .phy_ctrl_v_i(ctrl_v), .phy_data_i(din),
    .phy_start_i(start), .phy_idle_i(idle), .phy_term_i(term), .phy_term_len_i(tlen),
    .phy_ready_o(rdy0), .enc_v_o(v0), .enc_head_o(head0), .enc_data_o(data0), .enc_err_o(err0)
  );

  pcs_tx_enc #(.SCRAMBLE(1), .GB_PERIOD(GB)) u_scr (
    .clk(clk), .reset(reset), .phy_ctrl_v_i(ctrl_v), .phy_data_i(din),
    .phy_start_i(start), .phy_idle_i(idle), .phy_term_i(term), .phy_term_len_i(tlen),
    .phy_ready_o(rdy1), .enc_v_o(v1), .enc_head_o(head1), .enc_data_o(data1), .enc_err_o(err1)
  );

  typedef struct {
    logic [1:0]  head;
    logic [63:0] pay;
    logic        err;
  } blk_t;

  blk_t        sb_q[$];
  bit          pend = 1'b0;
  bit          rst_prev = 1'b1;
  int          errors = 0;
  int          checks = 0;
  int          gb_cnt = 0;
  logic [57:0] m_scr = '1;
  logic [57:0] m_dscr = '1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic blk_t encode(input logic cv, input logic [63:0] d, input logic [1:0] st,
                                  input logic id, input logic tm, input logic [3:0] len);
    blk_t        b;
    logic [7:0]  tc [8];
    logic [63:0] errp;
    tc = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    errp = 64'h1E;
    for (int i = 0; i < 8; i++) errp[8 + 7*i +: 7] = 7'h1E;
    b.head = 2'b10;
    b.err  = 1'b0;
    b.pay  = '0;
    if (id) begin
      b.pay = 64'h1E;
    end else if (!cv) begin
      if (st != 2'b00 || tm) begin b.pay = errp; b.err = 1'b1; end
      else begin b.head = 2'b01; b.pay = d; end
    end else if (st == 2'b01 && !tm) begin
      b.pay = d;
      b.pay[7:0] = 8'h78;
    end else if (st == 2'b10 && !tm) begin
      b.pay[63:40] = d[63:40];
      b.pay[7:0] = 8'h33;
    end else if (st == 2'b00 && tm && len < 4'd8) begin
      b.pay[7:0] = tc[len[2:0]];
      for (int j = 1; j <= int'(len); j++) b.pay[8*j +: 8] = d[8*(j-1) +: 8];
    end else begin
      b.pay = errp;
      b.err = 1'b1;
    end
    return b;
  endfunction

  // Reference x^58+x^39+1 (de)scrambler; descrambling shifts in the received bit.
  task automatic scr_step(input logic [63:0] x, input bit descr, input logic [57:0] st_in,
                          output logic [63:0] y, output logic [57:0] st_out);
    logic [57:0] s;
    s = st_in;
    for (int i = 0; i < 64; i++) begin
      y[i] = x[i] ^ s[38] ^ s[57];
      s = {s[56:0], descr ? x[i] : y[i]};
    end
    st_out = s;
  endtask

  task automatic cycle(output bit acc);
    blk_t        e;
    logic [63:0] exp_s, ds;
    bit          exp_rdy;
    @(negedge clk);
    if (pend) begin
      e = sb_q.pop_front();
      chk("v_plain", 64'(v0), 64'd1);
      chk("v_scr", 64'(v1), 64'd1);
      chk("head_plain", 64'(head0), 64'(e.head));
      chk("head_scr", 64'(head1), 64'(e.head));
      chk("err_plain", 64'(err0), 64'(e.err));
      chk("err_scr", 64'(err1), 64'(e.err));
      chk("data_plain", data0, e.pay);
      scr_step(e.pay, 1'b0, m_scr, exp_s, m_scr);
      chk("data_scr", data1, exp_s);
      scr_step(data1, 1'b1, m_dscr, ds, m_dscr);
      chk("descrambled", ds, e.pay);
    end else begin
      chk("v_idle_plain", 64'(v0), 64'd0);
      chk("v_idle_scr", 64'(v1), 64'd0);
      chk("err_idle", 64'(err0 | err1), 64'd0);
      if (rst_prev) begin
        chk("rst_head", 64'({head0, head1}), 64'd0);
        chk("rst_data_plain", data0, 64'd0);
        chk("rst_data_scr", data1, 64'd0);
      end
    end
    exp_rdy = !reset && (gb_cnt != GB - 1);
    chk("ready_plain", 64'(rdy0), 64'(exp_rdy));
    chk("ready_scr", 64'(rdy1), 64'(exp_rdy));
    if (exp_rdy) sb_q.push_back(encode(ctrl_v, din, start, idle, term, tlen));
    pend     = exp_rdy;
    rst_prev = reset;
    acc      = exp_rdy;
    @(posedge clk);
    if (reset) begin
      gb_cnt = 0;
      m_scr  = '1;
      m_dscr = '1;
      sb_q.delete();
    end else begin
      gb_cnt = (gb_cnt == GB - 1) ? 0 : gb_cnt + 1;
    end
    #1;
  endtask

  task automatic send(input logic cv, input logic [63:0] d, input logic [1:0] st,
                      input logic id, input logic tm, input logic [3:0] len);
    bit acc;
    acc = 1'b0;
    ctrl_v = cv; din = d; start = st; idle = id; term = tm; tlen = len;
    for (int t = 0; t < 4 && !acc; t++) cycle(acc);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_idle();
    send(1'b1, {$urandom(), $urandom()}, 2'b00, 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    bit          acc;
    logic [63:0] rd;
    reset = 1'b1;
    ctrl_v = 1'b0; din = '0; start = 2'b00; idle = 1'b1; term = 1'b0; tlen = 4'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(acc);
    reset = 1'b0;

    // Continuous idle from reset release spans stalls at cycles 32, 65 and 98.
    for (int i = 0; i < 100; i++) send_idle();

    // Directed encodings and error blocks.
    send(1'b1, 64'hD555555555555555, 2'b01, 1'b0, 1'b0, 4'd0);
    send(1'b0, 64'h0123456789ABCDEF, 2'b00, 1'b0, 1'b0, 4'd0);
    send(1'b1, 64'h1122334455CCBBAA, 2'b00, 1'b0, 1'b1, 4'd3);
    send(1'b1, 64'h1122334455CCBBAA, 2'b00, 1'b0, 1'b1, 4'd0);
    send(1'b1, 64'h8877665544332211, 2'b00, 1'b0, 1'b1, 4'd7);
    send(1'b1, 64'h8877665544332211, 2'b10, 1'b0, 1'b0, 4'd0);
    send(1'b1, 64'h8877665544332211, 2'b00, 1'b0, 1'b1, 4'd9);
    send(1'b1, 64'h8877665544332211, 2'b11, 1'b0, 1'b0, 4'd0);
    send(1'b1, 64'h8877665544332211, 2'b01, 1'b0, 1'b1, 4'd2);
    send(1'b1, 64'h8877665544332211, 2'b00, 1'b0, 1'b0, 4'd0);
    send(1'b0, 64'h8877665544332211, 2'b00, 1'b0, 1'b1, 4'd2);
    send(1'b0, 64'h8877665544332211, 2'b01, 1'b0, 1'b0, 4'd0);

    // Random legal frames, back-to-back term/start allowed.
    for (int f = 0; f < 40; f++) begin
      rd = {$urandom(), $urandom()};
      send(1'b1, rd, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0, 4'd0);
      for (int k = 0, n = $urandom_range(0, 5); k < n; k++)
        send(1'b0, {$urandom(), $urandom()}, 2'b00, 1'b0, 1'b0, 4'd0);
      send(1'b1, {$urandom(), $urandom()}, 2'b00, 1'b0, 1'b1, 4'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) send_idle();
    end

    // Reset pulse in the middle of a frame, then idles to re-check seed and pacing.
    send(1'b1, 64'hD555555555555555, 2'b01, 1'b0, 1'b0, 4'd0);
    send(1'b0, 64'hCAFEF00DDEADBEEF, 2'b00, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) cycle(acc);
    reset = 1'b0;
    send(1'b1, 64'hD555555555555555, 2'b01, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 40; i++) send_idle();
    cycle(acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
